// File: rtl/post_cn_block_reader_if.sv
// post_cn_block_reader_if: FIFO pop side plus block hand-off bus of the
// post-CryptoNight block reader. The slave modport is the reader; the
// master modport is the surrounding environment (FIFO + hash core).
interface post_cn_block_reader_if;
    logic [63:0]  fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [511:0] block_data;
    logic         block_valid;
    logic         block_ready;
    logic [3:0]   block_index;
    logic         block_last;
    logic [15:0]  msg_bits;
    logic         hdr_error;
    logic         busy;

    modport slave (
        input  fifo_dout, fifo_empty, block_ready,
        output fifo_rd_en, block_data, block_valid, block_index,
               block_last, msg_bits, hdr_error, busy
    );

    modport master (
        output fifo_dout, fifo_empty, block_ready,
        input  fifo_rd_en, block_data, block_valid, block_index,
               block_last, msg_bits, hdr_error, busy
    );
endinterface

// File: rtl/post_cn_block_reader.sv
// post_cn_block_reader: pops the framed 64-bit word stream of the final-hash
// load FIFO, parses the two header words and delivers the padded message as
// 512-bit blocks over a valid/ready handshake.
// Optional header validation is enabled by defining POST_CN_HDR_CHECK_EN;
// without it every header is accepted and hdr_error stays low.
module post_cn_block_reader (
    input  logic                  clk,
    input  logic                  rst,
    post_cn_block_reader_if.slave bus
);
    localparam int unsigned W_WORD  = 64;
    localparam int unsigned W_BLOCK = 512;
    localparam int unsigned W_LEN   = 16;
    localparam int unsigned W_IDX   = 4;
    localparam int unsigned W_CNT   = 3;

    localparam logic [1:0] S_HDR0 = 2'd0;
    localparam logic [1:0] S_HDR1 = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]         r_state, w_state_nxt;
    logic [W_CNT-1:0]   r_cnt,   w_cnt_nxt;
    logic [W_BLOCK-1:0] r_data,  w_data_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_last,  w_last_nxt;
    logic [W_IDX-1:0]   r_idx,   w_idx_nxt;
    logic [W_IDX-1:0]   r_nblk,  w_nblk_nxt;
    logic [W_LEN-1:0]   r_msg,   w_msg_nxt;
    logic               r_busy,  w_busy_nxt;
    logic               w_pop;
    logic               w_hs;

`ifdef POST_CN_HDR_CHECK_EN
    logic               r_err,   w_err_nxt;
    logic [W_LEN-1:0]   r_pad,   w_pad_nxt;
    logic               w_h0_ok;
    logic               w_h1_ok;

    // Header sanity: marker bit, zero fill, whole 512-bit blocks, 1..8 blocks
    assign w_h0_ok = bus.fifo_dout[63]
                  && (bus.fifo_dout[62:16] == 47'd0)
                  && (bus.fifo_dout[8:0] == 9'd0)
                  && (bus.fifo_dout[15:9] != 7'd0)
                  && (bus.fifo_dout[15:9] <= 7'd8);
    assign w_h1_ok = (bus.fifo_dout[63:16] == 48'd0)
                  && (bus.fifo_dout[15:0] <= r_pad);
`endif

    // Pop whenever the FIFO has data and no block is waiting for hand-off
    assign w_pop = !rst && !bus.fifo_empty && (r_state != S_OUT);
    assign w_hs  = r_valid && bus.block_ready;

    // Next-state and next-register values
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_idx_nxt   = r_idx;
        w_nblk_nxt  = r_nblk;
        w_msg_nxt   = r_msg;
        w_busy_nxt  = r_busy;
`ifdef POST_CN_HDR_CHECK_EN
        w_err_nxt   = 1'b0;
        w_pad_nxt   = r_pad;
`endif
        case (r_state)
            S_HDR0: begin
                if (w_pop) begin
`ifdef POST_CN_HDR_CHECK_EN
                    if (w_h0_ok) begin
                        w_nblk_nxt  = bus.fifo_dout[12:9];
                        w_pad_nxt   = bus.fifo_dout[15:0];
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_HDR1;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
`else
                    w_nblk_nxt  = bus.fifo_dout[12:9];
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_HDR1;
`endif
                end
            end
            S_HDR1: begin
                if (w_pop) begin
`ifdef POST_CN_HDR_CHECK_EN
                    if (w_h1_ok) begin
                        w_msg_nxt   = bus.fifo_dout[15:0];
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_FILL;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_HDR0;
                    end
`else
                    w_msg_nxt   = bus.fifo_dout[15:0];
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_FILL;
`endif
                end
            end
            S_FILL: begin
                if (w_pop) begin
                    // After eight shifts the first word sits in the top lane
                    w_data_nxt = {r_data[W_BLOCK-W_WORD-1:0], bus.fifo_dout};
                    w_cnt_nxt  = r_cnt + W_CNT'(1);
                    if (r_cnt == W_CNT'(7)) begin
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = (r_idx == (r_nblk - W_IDX'(1)));
                        w_state_nxt = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (w_hs) begin
                    w_valid_nxt = 1'b0;
                    if (r_last) begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_HDR0;
                    end else begin
                        w_idx_nxt   = r_idx + W_IDX'(1);
                        w_state_nxt = S_FILL;
                    end
                end
            end
            default: w_state_nxt = S_HDR0;
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HDR0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_nblk  <= '0;
            r_msg   <= '0;
            r_busy  <= 1'b0;
`ifdef POST_CN_HDR_CHECK_EN
            r_err   <= 1'b0;
            r_pad   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_idx   <= w_idx_nxt;
            r_nblk  <= w_nblk_nxt;
            r_msg   <= w_msg_nxt;
            r_busy  <= w_busy_nxt;
`ifdef POST_CN_HDR_CHECK_EN
            r_err   <= w_err_nxt;
            r_pad   <= w_pad_nxt;
`endif
        end
    end

    assign bus.fifo_rd_en  = w_pop;
    assign bus.block_data  = r_data;
    assign bus.block_valid = r_valid;
    assign bus.block_index = r_idx;
    assign bus.block_last  = r_last;
    assign bus.msg_bits    = r_msg;
    assign bus.busy        = r_busy;
`ifdef POST_CN_HDR_CHECK_EN
    assign bus.hdr_error   = r_err;
`else
    assign bus.hdr_error   = 1'b0;
`endif
endmodule

// File: tb/tb_post_cn_block_reader.sv
// tb_post_cn_block_reader: FIFO model feeding framed messages, a frame-level
// reference model producing the expected blocks, and a compare process that
// checks every handshake and per-cycle protocol rules.
module tb_post_cn_block_reader;
    typedef struct {
        logic [511:0] data;
        logic [3:0]   idx;
        logic         last;
        logic [15:0]  msg;
        int           cyc;
    } blk_t;

    logic clk;
    logic rst;
    post_cn_block_reader_if bus();

    post_cn_block_reader dut (.clk(clk), .rst(rst), .bus(bus));

    logic [63:0] fifo_q[$];
    logic [63:0] pl_q[$];
    blk_t        exp_q[$];
    blk_t        obs_q[$];
    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int cyc   = 0;
    int err_cnt = 0;
    bit rdy = 0, rdy_rand = 0, stall = 0, stall_rand = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Frame-level model: header words, payload, and the blocks they must yield
    task automatic push_frame(input int nb, input logic [15:0] unpad);
        logic [15:0] padded;
        blk_t        b;
        padded = 16'(nb * 512);
        if (pl_q.size() == 0)
            for (int i = 0; i < nb * 8; i++) pl_q.push_back({$urandom, $urandom});
        fifo_q.push_back({1'b1, 47'd0, padded});
        fifo_q.push_back({48'd0, unpad});
        for (int k = 0; k < nb; k++) begin
            b.data = '0;
            for (int j = 0; j < 8; j++) begin
                b.data[511 - 64*j -: 64] = pl_q[8*k + j];
                fifo_q.push_back(pl_q[8*k + j]);
            end
            b.idx  = 4'(k);
            b.last = (k == nb - 1);
            b.msg  = unpad;
            b.cyc  = 0;
            exp_q.push_back(b);
        end
        pl_q.delete();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain", 512'(exp_q.size()), 512'(0));
        exp_q.delete();
        repeat (3) step();
        chk("idle_busy", 512'(bus.busy), 512'(0));
        chk("idle_valid", 512'(bus.block_valid), 512'(0));
    endtask

    // FIFO model (first-word-fall-through) and ready generation
    initial begin
        bit will_pop;
        bit stall_now;
        bus.fifo_dout   = '0;
        bus.fifo_empty  = 1'b1;
        bus.block_ready = 1'b0;
        forever begin
            @(negedge clk);
            will_pop = bus.fifo_rd_en;
            @(posedge clk);
            #1;
            if (will_pop && fifo_q.size() > 0) begin
                fifo_q.delete(0);
                pops++;
            end
            stall_now = stall_rand ? ($urandom_range(0, 3) == 0) : stall;
            bus.fifo_empty  = stall_now || (fifo_q.size() == 0);
            bus.fifo_dout   = (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
            bus.block_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy;
        end
    end

    // Compare process: protocol rules every cycle, block contents on handshake
    bit           waiting = 0;
    logic [511:0] s_data;
    logic [3:0]   s_idx;
    logic         s_last;
    logic [15:0]  s_msg;
    always @(negedge clk) begin
        blk_t e, o;
        if (rst) begin
            waiting = 0;
        end else begin
            chk("rd_on_empty", 512'(bus.fifo_rd_en && bus.fifo_empty), 512'(0));
            if (bus.hdr_error) err_cnt++;
            if (waiting) begin
                chk("hold_valid", 512'(bus.block_valid), 512'(1));
                chk("hold_data", bus.block_data, s_data);
                chk("hold_idx", 512'(bus.block_index), 512'(s_idx));
                chk("hold_last", 512'(bus.block_last), 512'(s_last));
                chk("hold_msg", 512'(bus.msg_bits), 512'(s_msg));
            end
            waiting = bus.block_valid && !bus.block_ready;
            s_data = bus.block_data;
            s_idx  = bus.block_index;
            s_last = bus.block_last;
            s_msg  = bus.msg_bits;
            if (bus.block_valid) begin
                chk("rd_in_out", 512'(bus.fifo_rd_en), 512'(0));
                chk("busy_out", 512'(bus.busy), 512'(1));
                if (bus.block_ready) begin
                    o.data = bus.block_data;
                    o.idx  = bus.block_index;
                    o.last = bus.block_last;
                    o.msg  = bus.msg_bits;
                    o.cyc  = cyc;
                    obs_q.push_back(o);
                    chk("exp_avail", 512'(exp_q.size() > 0), 512'(1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("blk_data", o.data, e.data);
                        chk("blk_idx", 512'(o.idx), 512'(e.idx));
                        chk("blk_last", 512'(o.last), 512'(e.last));
                        chk("blk_msg", 512'(o.msg), 512'(e.msg));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        blk_t         b;
        int           n, base, p0, nb, lasts;
        logic [511:0] d0;
`ifdef POST_CN_HDR_CHECK_EN
        int           e0;
`endif
        rst = 1'b1;
        repeat (3) step();
        chk("rst_valid", 512'(bus.block_valid), 512'(0));
        chk("rst_busy", 512'(bus.busy), 512'(0));
        chk("rst_data", bus.block_data, 512'(0));
        chk("rst_idx", 512'(bus.block_index), 512'(0));
        chk("rst_last", 512'(bus.block_last), 512'(0));
        chk("rst_msg", 512'(bus.msg_bits), 512'(0));
        chk("rst_err", 512'(bus.hdr_error), 512'(0));
        chk("rst_rd", 512'(bus.fifo_rd_en), 512'(0));
        rst = 1'b0;
        step();

        // Blake frame with explicit payload
        rdy = 1;
        obs_q.delete();
        for (int i = 1; i <= 25; i++) pl_q.push_back(64'(i));
        pl_q.push_back(64'h8000000000000000);
        repeat (4) pl_q.push_back(64'd0);
        pl_q.push_back(64'h1);
        pl_q.push_back(64'h640);
        push_frame(4, 16'h640);
        chk("blake_h0", 512'(fifo_q[0]), 512'(64'h8000000000000800));
        wait_done(400);
        chk("blake_nblk", 512'(obs_q.size()), 512'(4));
        if (obs_q.size() == 4) begin
            b = obs_q[0];
            chk("blake_b0_w0", 512'(b.data[511:448]), 512'(1));
            b = obs_q[3];
            chk("blake_b3_w7", 512'(b.data[63:0]), 512'(64'h640));
            chk("blake_b3_last", 512'(b.last), 512'(1));
            chk("blake_b3_idx", 512'(b.idx), 512'(3));
            chk("blake_msg", 512'(b.msg), 512'(16'h640));
            for (int i = 1; i < 4; i++)
                chk("blake_gap", 512'(obs_q[i].cyc - obs_q[i-1].cyc), 512'(9));
        end

        // JH frame: 5 blocks
        obs_q.delete();
        push_frame(5, 16'h900);
        chk("jh_h0", 512'(fifo_q[0]), 512'(64'h8000000000000A00));
        chk("jh_words", 512'(fifo_q.size()), 512'(42));
        wait_done(400);
        chk("jh_nblk", 512'(obs_q.size()), 512'(5));
        lasts = 0;
        foreach (obs_q[i]) if (obs_q[i].last) lasts++;
        chk("jh_lasts", 512'(lasts), 512'(1));
        if (obs_q.size() == 5) begin
            b = obs_q[4];
            chk("jh_last_idx", 512'(b.idx), 512'(4));
        end

        // Backpressure on block 1
        rdy = 0;
        push_frame(4, 16'd1000);
        for (int bi = 0; bi < 4; bi++) begin
            n = 0;
            while (!bus.block_valid && n < 100) begin
                step();
                n++;
            end
            chk("bp_valid", 512'(bus.block_valid), 512'(1));
            if (bi == 1) begin
                d0 = bus.block_data;
                chk("bp_idx", 512'(bus.block_index), 512'(1));
                repeat (10) begin
                    step();
                    chk("bp_stable", bus.block_data, d0);
                    chk("bp_rd", 512'(bus.fifo_rd_en), 512'(0));
                end
            end
            rdy = 1;
            step();
            rdy = 0;
            step();
            chk("bp_taken", 512'(bus.block_valid), 512'(0));
        end
        rdy = 1;
        wait_done(400);

        // FIFO underflow after payload word 3
        base = pops;
        push_frame(4, 16'h7ff);
        n = 0;
        while (pops < base + 5 && n < 100) begin
            step();
            n++;
        end
        stall = 1;
        step();
        p0 = pops;
        repeat (5) begin
            step();
            chk("uf_rd", 512'(bus.fifo_rd_en), 512'(0));
        end
        chk("uf_pops", 512'(pops), 512'(p0));
        chk("uf_novalid", 512'(bus.block_valid), 512'(0));
        stall = 0;
        wait_done(400);

        // Reset after block 1's 4th word
        base = pops;
        push_frame(4, 16'h640);
        n = 0;
        while (pops < base + 14 && n < 200) begin
            step();
            n++;
        end
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        step();
        chk("mr_valid", 512'(bus.block_valid), 512'(0));
        chk("mr_busy", 512'(bus.busy), 512'(0));
        chk("mr_data", bus.block_data, 512'(0));
        chk("mr_idx", 512'(bus.block_index), 512'(0));
        chk("mr_msg", 512'(bus.msg_bits), 512'(0));
        chk("mr_rd", 512'(bus.fifo_rd_en), 512'(0));
        rst = 1'b0;
        step();
        obs_q.delete();
        push_frame(4, 16'h640);
        wait_done(400);
        chk("mr_fresh", 512'(obs_q.size()), 512'(4));

        // Randomized frames with random ready and FIFO stalls
        rdy_rand = 1;
        stall_rand = 1;
        for (int f = 0; f < 6; f++) begin
            nb = int'($urandom_range(1, 8));
            push_frame(nb, 16'($urandom_range(0, nb * 512)));
        end
        wait_done(6000);
        rdy_rand = 0;
        stall_rand = 0;

`ifdef POST_CN_HDR_CHECK_EN
        e0 = err_cnt;
        fifo_q.push_back(64'h0000000000000800);
        push_frame(4, 16'h640);
        wait_done(400);
        chk("h0_err", 512'(err_cnt), 512'(e0 + 1));
        e0 = err_cnt;
        fifo_q.push_back(64'h8000000000000800);
        fifo_q.push_back(64'h1000);
        push_frame(2, 16'h100);
        wait_done(400);
        chk("h1_err", 512'(err_cnt), 512'(e0 + 1));
`else
        // Length field 0 in H0[12:9] means 16 blocks
        obs_q.delete();
        push_frame(16, 16'h1234);
        wait_done(1000);
        chk("b16_nblk", 512'(obs_q.size()), 512'(16));
        if (obs_q.size() == 16) begin
            b = obs_q[15];
            chk("b16_last", 512'(b.last), 512'(1));
            chk("b16_idx", 512'(b.idx), 512'(15));
        end
        chk("no_hdr_err", 512'(err_cnt), 512'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/post_cn_block_reader.md
# post_cn_block_reader

Consumer end of the post-CryptoNight final-hash load FIFO. Pops the framed 64-bit word stream from the FIFO and parses its two header words: padded length and unpadded length. Assembles the padded message into 512-bit blocks and hands each block to the downstream Blake/Groestl/JH/Skein core with a valid/ready handshake, plus block index, last-block flag and message length.

## Interface
Parameters:
- none; frame format is fixed.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fifo_dout`  in  64  head word of the load FIFO, first-word-fall-through.
- `fifo_empty`  in  1  FIFO empty; `fifo_dout` invalid when high.
- `fifo_rd_en`  out  1  pop strobe; combinational from state and `fifo_empty`.
- `block_data`  out  512  assembled block; first word of the block in [511:448], eighth word in [63:0].
- `block_valid`  out  1  block available; registered.
- `block_ready`  in  1  downstream accepts; handshake when `block_valid && block_ready`.
- `block_index`  out  4  0-based block number within the current frame.
- `block_last`  out  1  current block is the final block of the frame.
- `msg_bits`  out  16  unpadded message length in bits, from header word 1.
- `hdr_error`  out  1  one-cycle pulse on a rejected header word.
- `busy`  out  1  high from header-0 acceptance until the last block handshake.

## Operation
- Frame layout:
  - H0 = {1'b1, 47'b0, padded_len[15:0]}
  - H1 = {48'b0, unpadded_len[15:0]}
  - followed by padded_len/64 payload words.
  - Examples: 0x8000000000000800 / 0x640 gives 32 words, 4 blocks. 0x8000000000000A00 / 0x640 gives 40 words, 5 blocks.
- States: S_HDR0, S_HDR1, S_FILL, S_OUT. The FIFO is popped only in S_HDR0, S_HDR1 and S_FILL, whenever `!fifo_empty`. Each pop consumes `fifo_dout` in the same cycle.
- S_HDR0:
  - On pop, latch nblocks = H0[12:9]; the value 0 means 16.
  - Go to S_HDR1.
- S_HDR1:
  - On pop, latch `msg_bits` = H1[15:0].
  - Clear the word counter and `block_index`.
  - Go to S_FILL.
- S_FILL:
  - Each pop shifts the word into the block register, first word ending in [511:448].
  - A 3-bit word counter increments per pop.
  - The pop with counter = 7 goes to S_OUT and sets `block_valid`.
  - `block_last` = (block_index == nblocks-1).
- S_OUT:
  - No pops.
  - Hold `block_data`, `block_index`, `block_last`, `msg_bits` stable until handshake.
  - On handshake, clear `block_valid`.
  - If `block_last`, go to S_HDR0 and drop `busy`. Otherwise increment `block_index` and go to S_FILL.
- Padding words are forwarded as payload, unmodified; the block does not strip padding.
- `block_index` wraps naturally at 16 blocks; nblocks ≤ 16, so no overflow within a frame.

## Timing
- Reset state, entered on the first edge with `rst` high, overriding everything:
  - state S_HDR0.
  - `block_valid`, `block_last`, `hdr_error`, `busy` = 0.
  - `block_data`, `block_index`, `msg_bits` = 0.
  - word counter = 0.
- `fifo_rd_en` is 0 while `rst` is high.
- Latency: the pop of a block's 8th word at edge t gives `block_valid` high after edge t+1 (registered).
- Minimum spacing between blocks is 9 cycles: 8 pops plus 1 handshake cycle. Each frame adds 2 header cycles.
- FIFO empty mid-block: the counter holds and the partial block is retained. No timeout.
- `block_ready` high before `block_valid`: no effect. The handshake completes on the first cycle `block_valid` is high.
- Reset mid-frame: the partial block and header are discarded. The remaining words of that frame reach S_HDR0 and are parsed as headers; upstream resets the FIFO together with this block.

## Configuration
- `POST_CN_HDR_CHECK_EN` defined: headers are validated.
  - H0 is accepted only if bit63 = 1, bits[62:16] = 0, bits[8:0] = 0 and padded_len/512 is in 1..8. Otherwise the word is popped and discarded, `hdr_error` pulses for 1 cycle, and the state stays in S_HDR0.
  - H1 is accepted only if bits[63:16] = 0 and unpadded_len ≤ padded_len. Otherwise the word is popped, `hdr_error` pulses, and the state returns to S_HDR0.
- Macro undefined: no checks. Every H0 and H1 is accepted as described in Operation, and `hdr_error` is tied to 0.

## Test plan
- Blake frame: 0x8000000000000800, 0x640, payload words 1..25, 0x80<<56, four 0s, 0x01, 0x640, with `block_ready` = 1 -> 4 blocks:
  - block 0 `block_data[511:448]` = 1.
  - block 3 `block_data[63:0]` = 0x640 with `block_last` = 1 and `block_index` = 3.
  - `msg_bits` = 0x640.
  - blocks 9 cycles apart.
- JH frame: 42 words with H0 = 0x8000000000000A00 -> 5 blocks, `block_last` only on index 4, then return to S_HDR0 and `busy` = 0.
- Backpressure: `block_ready` held 0 for 10 cycles at block 1 -> `block_data` stable, `fifo_rd_en` = 0 throughout. Accepted on the first cycle `block_ready` returns to 1.
- FIFO underflow: `fifo_empty` asserted 5 cycles after payload word 3 -> no pops, counter frozen. The block completes correctly once data resumes.
- With `POST_CN_HDR_CHECK_EN`:
  - H0 = 0x0000000000000800 -> one `hdr_error` pulse, word discarded. A following valid frame decodes normally.
  - H1 = 0x1000 against padded_len 0x800 -> `hdr_error`, return to S_HDR0.
- `rst` pulsed after block 1's 4th word -> all outputs 0 the next cycle, state S_HDR0. A fresh frame after a FIFO flush decodes as 4 blocks.
